// File: rtl/sseg_scan.sv
// Four-digit common-anode seven-segment scanner for the stopwatch display.
// Multiplexes digits, decodes BCD, adds decimal points, leading-zero blank and flashing.
module sseg_scan #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned FLASH_DIV   = 250
) (
    input  logic        clk,
    input  logic        R,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic        lz_en,
    input  logic        flash_en,
    output logic [3:0]  an,
    output logic [6:0]  sseg,
    output logic        dp
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [PW-1:0] PMax = PW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FMax = FW'(FLASH_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          off_q, off_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    sseg_q, sseg_d;
    logic          dp_q, dp_d;

    logic          tick;
    logic [3:0]    nibble;
    logic          blank;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_comb begin
        tick = (pre_q == PMax);
        pre_d = tick ? '0 : pre_q + 1'b1;

        // Slot 0 reads live digits so the value it shows equals the one being snapshotted.
        unique case (idx_q)
            2'd0:    nibble = digits[3:0];
            2'd1:    nibble = snap_q[7:4];
            2'd2:    nibble = snap_q[11:8];
            default: nibble = snap_q[15:12];
        endcase
        blank = (idx_q == 2'd3) && lz_en && (nibble == 4'd0);

        idx_d  = idx_q;
        snap_d = snap_q;
        fcnt_d = fcnt_q;
        off_d  = off_q;
        an_d   = an_q;
        sseg_d = sseg_q;
        dp_d   = dp_q;

        if (!flash_en) begin
            fcnt_d = '0;
            off_d  = 1'b0;
        end

        if (tick) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd0) begin
                snap_d = digits;
            end
            sseg_d = blank ? 7'h7F : decode(nibble);
            dp_d   = blank ? 1'b1 : ~dp_mask[idx_q];
            an_d   = (flash_en && off_q) ? 4'b1111 : ~(4'b0001 << idx_q);
            if (flash_en) begin
                if (fcnt_q == FMax) begin
                    fcnt_d = '0;
                    off_d  = ~off_q;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            pre_q  <= '0;
            idx_q  <= 2'd0;
            snap_q <= 16'h0000;
            fcnt_q <= '0;
            off_q  <= 1'b0;
            an_q   <= 4'b1111;
            sseg_q <= 7'h7F;
            dp_q   <= 1'b1;
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            fcnt_q <= fcnt_d;
            off_q  <= off_d;
            an_q   <= an_d;
            sseg_q <= sseg_d;
            dp_q   <= dp_d;
        end
    end

    assign an   = an_q;
    assign sseg = sseg_q;
    assign dp   = dp_q;

endmodule

// File: tb/tb_sseg_scan.sv
// Bench for sseg_scan: hand-derived vector table, directed corner sequences and
// randomized traffic checked every cycle against a tick-level behavioural model.
module tb_sseg_scan;

    localparam int RD = 4;
    localparam int FD = 2;

    logic        clk = 1'b0;
    logic        R = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_mask = 4'h0;
    logic        lz_en = 1'b0;
    logic        flash_en = 1'b0;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;

    int vectors = 0;
    int miscompares = 0;

    sseg_scan #(.REFRESH_DIV(RD), .FLASH_DIV(FD)) dut (
        .clk      (clk),
        .R        (R),
        .digits   (digits),
        .dp_mask  (dp_mask),
        .lz_en    (lz_en),
        .flash_en (flash_en),
        .an       (an),
        .sseg     (sseg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Model: cycles since reset give the tick number; flash state is the count of
    // flash-enabled ticks since flash_en was last low.
    int          m_cyc = 0;
    int          m_fl = 0;
    logic [15:0] m_snap = 16'h0;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;

    always @(posedge clk or posedge R) begin
        int slot;
        logic [3:0] nib;
        logic blank, dark;
        if (R) begin
            m_cyc = 0; m_fl = 0; m_snap = 16'h0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            if (!flash_en) m_fl = 0;
            m_cyc = m_cyc + 1;
            if (m_cyc % RD == 0) begin
                slot = (m_cyc / RD - 1) % 4;
                if (slot == 0) m_snap = digits;
                nib = m_snap[slot*4 +: 4];
                blank = (slot == 3) && lz_en && (nib == 4'd0);
                e_seg = blank ? 7'h7F : seg_of(nib);
                e_dp = blank ? 1'b1 : ~dp_mask[slot];
                dark = flash_en && (((m_fl / FD) % 2) == 1);
                e_an = dark ? 4'hF : ~(4'b0001 << slot);
                if (flash_en) m_fl = m_fl + 1;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        vectors++;
        if (an !== e_an || sseg !== e_seg || dp !== e_dp) begin
            miscompares++;
            $display("FAIL model t=%0t: an=%b sseg=%h dp=%b, required an=%b sseg=%h dp=%b",
                     $time, an, sseg, dp, e_an, e_seg, e_dp);
        end
    end

    task automatic chk(input string name, input logic [3:0] a, input logic [6:0] s,
                       input logic d);
        vectors++;
        if (an !== a || sseg !== s || dp !== d) begin
            miscompares++;
            $display("FAIL %s: an=%b sseg=%h dp=%b, required an=%b sseg=%h dp=%b",
                     name, an, sseg, dp, a, s, d);
        end
    endtask

    task automatic reset_with(input logic [15:0] dg, input logic [3:0] dm, input logic lz,
                              input logic fe);
        @(negedge clk);
        R = 1'b1;
        #1 chk("reset_dark", 4'hF, 7'h7F, 1'b1);
        repeat (3) @(negedge clk);
        digits = dg; dp_mask = dm; lz_en = lz; flash_en = fe;
        R = 1'b0;
    endtask

    task automatic next_tick();
        repeat (RD) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] dg;
        logic [3:0]  dm;
        logic        lz;
        logic [6:0]  seg [4];
        logic [3:0]  dpx;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{16'h1234, 4'b0000, 1'b0, '{7'h19, 7'h30, 7'h24, 7'h79}, 4'b1111};
        tbl[1] = '{16'h0950, 4'b0100, 1'b1, '{7'h40, 7'h12, 7'h10, 7'h7F}, 4'b1011};
        tbl[2] = '{16'hABCD, 4'b0000, 1'b1, '{7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111};
        tbl[3] = '{16'h0950, 4'b1000, 1'b0, '{7'h40, 7'h12, 7'h10, 7'h40}, 4'b0111};
        tbl[4] = '{16'h8765, 4'b1111, 1'b1, '{7'h12, 7'h02, 7'h78, 7'h00}, 4'b0000};

        repeat (20) @(negedge clk);
        chk("held_reset", 4'hF, 7'h7F, 1'b1);

        for (int i = 0; i < 5; i++) begin
            reset_with(tbl[i].dg, tbl[i].dm, tbl[i].lz, 1'b0);
            repeat (RD - 1) @(negedge clk);
            #1 chk("pre_first_tick", 4'hF, 7'h7F, 1'b1);
            @(negedge clk);
            #1 chk("slot0", 4'b1110, tbl[i].seg[0], tbl[i].dpx[0]);
            for (int k = 1; k < 4; k++) begin
                next_tick();
                chk("slot", ~(4'b0001 << k), tbl[i].seg[k], tbl[i].dpx[k]);
            end
        end

        // Digits change while slot 2 is pending: the old frame completes untouched.
        reset_with(16'h0959, 4'b0000, 1'b0, 1'b0);
        next_tick();
        next_tick();
        digits = 16'h1000;
        next_tick(); chk("snap_s2", 4'b1011, 7'h10, 1'b1);
        next_tick(); chk("snap_s3", 4'b0111, 7'h40, 1'b1);
        next_tick(); chk("new_s0", 4'b1110, 7'h40, 1'b1);
        next_tick(); chk("new_s1", 4'b1101, 7'h40, 1'b1);
        next_tick(); chk("new_s2", 4'b1011, 7'h40, 1'b1);
        next_tick(); chk("new_s3", 4'b0111, 7'h79, 1'b1);

        // Flash: two lit ticks, two dark, and release restores the next tick.
        reset_with(16'h1234, 4'b0000, 1'b0, 1'b1);
        next_tick(); chk("fl_t1", 4'b1110, 7'h19, 1'b1);
        next_tick(); chk("fl_t2", 4'b1101, 7'h30, 1'b1);
        next_tick(); chk("fl_t3", 4'b1111, 7'h24, 1'b1);
        next_tick(); chk("fl_t4", 4'b1111, 7'h79, 1'b1);
        next_tick(); chk("fl_t5", 4'b1110, 7'h19, 1'b1);
        next_tick(); chk("fl_t6", 4'b1101, 7'h30, 1'b1);
        next_tick(); chk("fl_t7", 4'b1111, 7'h24, 1'b1);
        flash_en = 1'b0;
        next_tick(); chk("fl_off", 4'b0111, 7'h79, 1'b1);

        // Reset mid-slot 2, then slot 0 exactly RD clocks after release.
        reset_with(16'h1234, 4'b0000, 1'b0, 1'b0);
        next_tick(); next_tick(); next_tick();
        @(negedge clk);
        R = 1'b1;
        #1 chk("mid_reset", 4'hF, 7'h7F, 1'b1);
        repeat (3) @(negedge clk);
        R = 1'b0;
        repeat (RD - 1) @(negedge clk);
        #1 chk("mid_pre", 4'hF, 7'h7F, 1'b1);
        @(negedge clk);
        #1 chk("mid_slot0", 4'b1110, 7'h19, 1'b1);

        // Random traffic, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                digits = 16'($urandom);
                if ($urandom_range(0, 2) == 0) digits[15:12] = 4'h0;
            end
            if ($urandom_range(0, 7) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
            if ($urandom_range(0, 40) == 0) flash_en = ~flash_en;
            if ($urandom_range(0, 700) == 0) R = 1'b1;
            else R = 1'b0;
        end
        @(negedge clk);
        #3;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
